// File: rtl/debug_trace_pkg.sv
// -----------------------------------------------------------------------------
// debug_trace_pkg
// Shared types and constants for the debug trace receive path.
//   NIBBLES_PER_FRAME : nibbles per trace frame (LSB nibble first on the wire)
//   PC_LSB / PC_MSB   : PC bit range carried by one frame
//   trace_word_t      : one reassembled frame, pc[PC_MSB:PC_LSB]
//   trace_state_t     : deserializer FSM states
// -----------------------------------------------------------------------------
package debug_trace_pkg;

    localparam int NIBBLES_PER_FRAME = 4;
    localparam int PC_LSB            = 2;
    localparam int PC_MSB            = 17;

    typedef logic [PC_MSB-PC_LSB:0] trace_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        N1   = 2'd1,
        N2   = 2'd2,
        N3   = 2'd3
    } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO with a registered head word and valid/ready pop side.
// Parameters:
//   DEPTH  : number of words (power of two, >= 2)
//   WORD_T : stored word type
// Ports:
//   clock_i, resetn_i : clock, asynchronous active-low reset
//   clear_i           : synchronous flush, wins over push and pop
//   push_i/push_data_i: write request and data
//   pop_ready_i       : consumer accepts head word (pop when valid_o=1)
//   valid_o, data_o   : FIFO non-empty, registered head word
//   level_o           : occupancy 0..DEPTH
//   drop_o            : pulse, a push was rejected because the FIFO was full
// -----------------------------------------------------------------------------
module trace_fifo
    import debug_trace_pkg::*;
#(
    parameter int  DEPTH  = 8,
    parameter type WORD_T = trace_word_t
) (
    input  logic                     clock_i,
    input  logic                     resetn_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  WORD_T                    push_data_i,
    input  logic                     pop_ready_i,
    output logic                     valid_o,
    output WORD_T                    data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    WORD_T              mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    WORD_T              head_q, head_d;
    logic               full;
    logic               pop;
    logic               push_ok;
    logic               do_write;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign pop     = (level_q != '0) && pop_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        do_write = 1'b0;
        drop_o   = 1'b0;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            head_d   = '0;
        end else begin
            do_write = push_ok;
            drop_o   = push_i && !push_ok;
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop)      level_d = level_q + 1'b1;
            else if (pop && !push_ok) level_d = level_q - 1'b1;
            // Preload the head register with whatever word will be at the
            // front next cycle; bypass the write when it lands in that slot.
            if (level_d != '0) begin
                if (push_ok && (wr_ptr_q == rd_ptr_d)) head_d = push_data_i;
                else                                   head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Storage carries no reset; only pointers and the head are reset.
    always_ff @(posedge clock_i) begin
        if (do_write) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    assign valid_o = (level_q != '0);
    assign data_o  = head_q;
    assign level_o = level_q;

endmodule

// File: rtl/debug_trace_deserializer.sv
// -----------------------------------------------------------------------------
// debug_trace_deserializer
// Receives the 6-pin debug trace bus {debug_clock, valid, data[3:0]},
// synchronizes it into the local clock domain, samples on the falling edge
// of debug_clock, reassembles 4-nibble frames into pc[17:2] and queues them.
// Parameters:
//   DEPTH       : FIFO depth in words (power of two, 2..64)
//   SYNC_STAGES : synchronizer flops per input bit (>= 2)
// Ports:
//   clock, resetn            : local clock (>= 3x debug_clock), async active-low reset
//   dbg_clock_in/valid/data  : asynchronous trace pins
//   clear                    : synchronous flush of FIFO and sticky flags
//   out_valid/out_ready/out_data : head-of-FIFO handshake, {nib3..nib0}
//   level                    : FIFO occupancy
//   overflow                 : sticky, frame dropped on full FIFO
//   frame_error              : sticky, valid seen mid-frame
//   drop_count               : only with DEBUG_TRACE_DROP_COUNT_EN defined;
//                              saturating count of drops and frame errors
// -----------------------------------------------------------------------------
module debug_trace_deserializer
    import debug_trace_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   dbg_clock_in,
    input  logic                   dbg_valid_in,
    input  logic [3:0]             dbg_data_in,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   frame_error
`ifdef DEBUG_TRACE_DROP_COUNT_EN
    ,
    output logic [15:0]            drop_count
`endif
);

    // ---------------- input synchronizers ----------------
    logic [5:0]                        pins;
    logic [SYNC_STAGES-1:0][5:0]       sync_q;
    logic                              hist_q;
    logic                              strobe;
    logic                              s_valid;
    logic [3:0]                        s_data;

    assign pins = {dbg_clock_in, dbg_valid_in, dbg_data_in};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
            hist_q <= sync_q[SYNC_STAGES-1][5];
        end
    end

    // Falling debug_clock is mid-symbol; valid/data come from the same stage
    // as the edge so all three are consistent.
    assign strobe  = hist_q & ~sync_q[SYNC_STAGES-1][5];
    assign s_valid = sync_q[SYNC_STAGES-1][4];
    assign s_data  = sync_q[SYNC_STAGES-1][3:0];

    // ---------------- frame FSM ----------------
    trace_state_t                              state_q, state_d;
    logic [NIBBLES_PER_FRAME-2:0][3:0]         nib_q, nib_d;
    logic                                      push_q, push_d;
    trace_word_t                               word_q, word_d;
    logic                                      ferr_event;

    always_comb begin
        state_d    = state_q;
        nib_d      = nib_q;
        push_d     = 1'b0;
        word_d     = word_q;
        ferr_event = 1'b0;
        if (strobe) begin
            if (s_valid && (state_q != IDLE)) begin
                // Truncated frame: drop what we have and resync on this nibble.
                ferr_event = 1'b1;
                nib_d[0]   = s_data;
                state_d    = N1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (s_valid) begin
                            nib_d[0] = s_data;
                            state_d  = N1;
                        end
                    end
                    N1: begin
                        nib_d[1] = s_data;
                        state_d  = N2;
                    end
                    N2: begin
                        nib_d[2] = s_data;
                        state_d  = N3;
                    end
                    N3: begin
                        word_d  = {s_data, nib_q};
                        push_d  = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            nib_q   <= '0;
            push_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
            push_q  <= push_d;
            word_q  <= word_d;
        end
    end

    // ---------------- FIFO ----------------
    logic fifo_drop;

    trace_fifo #(
        .DEPTH  (DEPTH),
        .WORD_T (trace_word_t)
    ) u_fifo (
        .clock_i     (clock),
        .resetn_i    (resetn),
        .clear_i     (clear),
        .push_i      (push_q),
        .push_data_i (word_q),
        .pop_ready_i (out_ready),
        .valid_o     (out_valid),
        .data_o      (out_data),
        .level_o     (level),
        .drop_o      (fifo_drop)
    );

    // ---------------- sticky flags ----------------
    logic overflow_q, overflow_d;
    logic frame_error_q, frame_error_d;

    always_comb begin
        overflow_d    = overflow_q | fifo_drop;
        frame_error_d = frame_error_q | ferr_event;
        if (clear) begin
            overflow_d    = 1'b0;
            frame_error_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            overflow_q    <= overflow_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign overflow    = overflow_q;
    assign frame_error = frame_error_q;

`ifdef DEBUG_TRACE_DROP_COUNT_EN
    logic [15:0] drop_count_q, drop_count_d;
    logic [16:0] drop_sum;

    // A drop (from last cycle's push) and a frame error can coincide: add 2.
    assign drop_sum = {1'b0, drop_count_q} + 17'(fifo_drop) + 17'(ferr_event);

    always_comb begin
        drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (clear) drop_count_d = '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) drop_count_q <= '0;
        else         drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_debug_trace_deserializer.sv
module tb_debug_trace_deserializer;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        dbg_clock_in = 1'b0;
    logic        dbg_valid_in = 1'b0;
    logic [3:0]  dbg_data_in = 4'h0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [3:0]  level;
    logic        overflow;
    logic        frame_error;
`ifdef DEBUG_TRACE_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    debug_trace_deserializer #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .dbg_clock_in (dbg_clock_in),
        .dbg_valid_in (dbg_valid_in),
        .dbg_data_in  (dbg_data_in),
        .clear        (clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level),
        .overflow     (overflow),
        .frame_error  (frame_error)
`ifdef DEBUG_TRACE_DROP_COUNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    typedef struct {
        logic [15:0] word;
        logic [3:0]  exp_level;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One symbol: rising edge with new data, falling edge 4 cycles later.
    // Returns on the negedge where debug_clock was driven low.
    task automatic drive_sym(input logic v, input logic [3:0] d);
        @(negedge clock);
        dbg_clock_in = 1'b1;
        dbg_valid_in = v;
        dbg_data_in  = d;
        wait_neg(4);
        dbg_clock_in = 1'b0;
    endtask

    // Full frame; returns 4 cycles after the nib3 fall, when the push is visible.
    task automatic send_frame(input logic [15:0] w);
        for (int i = 0; i < 4; i++) begin
            drive_sym(i == 0, w[i*4 +: 4]);
            wait_neg(4);
        end
    endtask

    task automatic pop_word(input string name, input logic [15:0] exp);
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_data"}, out_data, exp);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        tbl[0] = '{16'h1111, 4'd1, 1'b0};
        tbl[1] = '{16'h2222, 4'd2, 1'b0};
        tbl[2] = '{16'h3333, 4'd3, 1'b0};
        tbl[3] = '{16'h4444, 4'd4, 1'b0};
        tbl[4] = '{16'h5555, 4'd5, 1'b0};
        tbl[5] = '{16'h6666, 4'd6, 1'b0};
        tbl[6] = '{16'h7777, 4'd7, 1'b0};
        tbl[7] = '{16'h8888, 4'd8, 1'b0};
        tbl[8] = '{16'h9999, 4'd8, 1'b1};

        // ---- reset state ----
        wait_neg(3);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_level", level, 4'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        resetn = 1'b1;
        wait_neg(2);

        // ---- single frame pc=0x0001_2344 -> nibbles 1,D,8,4 ----
        drive_sym(1'b1, 4'h1); wait_neg(4);
        drive_sym(1'b0, 4'hD); wait_neg(4);
        drive_sym(1'b0, 4'h8); wait_neg(4);
        drive_sym(1'b0, 4'h4);
        // strobe sits 2 cycles after the fall; out_valid 2 cycles after strobe
        wait_neg(3);
        check("t1_valid_before", out_valid, 1'b0);
        wait_neg(1);
        check("t1_valid_rise", out_valid, 1'b1);
        check("t1_data", out_data, 16'h48D1);
        check("t1_level", level, 4'd1);
        pop_word("t1_pop", 16'h48D1);
        check("t1_level_after_pop", level, 4'd0);

        // ---- fill to full, 9th frame dropped ----
        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].word);
            check($sformatf("t2_level_%0d", i), level, tbl[i].exp_level);
            check($sformatf("t2_ovf_%0d", i), overflow, tbl[i].exp_ovf);
            check($sformatf("t2_head_%0d", i), out_data, tbl[0].word);
        end
`ifdef DEBUG_TRACE_DROP_COUNT_EN
        check("t2_drop_count", drop_count, 16'd1);
`endif
        for (int i = 0; i < 8; i++) begin
            pop_word($sformatf("t2_pop_%0d", i), tbl[i].word);
        end
        check("t2_empty_level", level, 4'd0);
        check("t2_empty_valid", out_valid, 1'b0);
        pulse_clear();
        check("t2_ovf_cleared", overflow, 1'b0);
`ifdef DEBUG_TRACE_DROP_COUNT_EN
        check("t2_drop_count_cleared", drop_count, 16'd0);
`endif

        // ---- truncated frame then 0x1234 ----
        drive_sym(1'b1, 4'hA); wait_neg(4);
        drive_sym(1'b0, 4'hB); wait_neg(4);
        send_frame(16'h1234);
        check("t3_frame_error", frame_error, 1'b1);
        check("t3_level", level, 4'd1);
        check("t3_data", out_data, 16'h1234);
        wait_neg(6);
        check("t3_level_stable", level, 4'd1);
        pop_word("t3_pop", 16'h1234);
        check("t3_level_after_pop", level, 4'd0);
        pulse_clear();
        check("t3_ferr_cleared", frame_error, 1'b0);

        // ---- full FIFO, pop in the push cycle ----
        for (int i = 0; i < 8; i++) send_frame(tbl[i].word);
        check("t4_level_full", level, 4'd8);
        drive_sym(1'b1, 4'hE); wait_neg(4);
        drive_sym(1'b0, 4'hD); wait_neg(4);
        drive_sym(1'b0, 4'h0); wait_neg(4);
        drive_sym(1'b0, 4'hC);
        wait_neg(3);
        out_ready = 1'b1;
        wait_neg(1);
        out_ready = 1'b0;
        check("t4_level", level, 4'd8);
        check("t4_overflow", overflow, 1'b0);
        check("t4_head", out_data, tbl[1].word);
        for (int i = 1; i < 8; i++) begin
            pop_word($sformatf("t4_pop_%0d", i), tbl[i].word);
        end
        pop_word("t4_pop_tail", 16'hC0DE);
        check("t4_level_end", level, 4'd0);

        // ---- reset mid-frame, then 0xBEEF ----
        drive_sym(1'b1, 4'h1); wait_neg(4);
        drive_sym(1'b0, 4'h2); wait_neg(4);
        resetn = 1'b0;
        wait_neg(1);
        resetn = 1'b1;
        wait_neg(2);
        send_frame(16'hBEEF);
        check("t5_frame_error", frame_error, 1'b0);
        check("t5_overflow", overflow, 1'b0);
        check("t5_level", level, 4'd1);
        check("t5_data", out_data, 16'hBEEF);
        pop_word("t5_pop", 16'hBEEF);
        check("t5_level_end", level, 4'd0);

        // ---- clear with level=3, overflow=1, push in same cycle ----
        for (int i = 0; i < 9; i++) send_frame(tbl[i].word);
        for (int i = 0; i < 5; i++) begin
            pop_word($sformatf("t6_pop_%0d", i), tbl[i].word);
        end
        check("t6_level_pre", level, 4'd3);
        check("t6_ovf_pre", overflow, 1'b1);
        drive_sym(1'b1, 4'hA); wait_neg(4);
        drive_sym(1'b0, 4'h5); wait_neg(4);
        drive_sym(1'b0, 4'hA); wait_neg(4);
        drive_sym(1'b0, 4'h5);
        wait_neg(3);
        clear = 1'b1;
        wait_neg(1);
        clear = 1'b0;
        check("t6_level", level, 4'd0);
        check("t6_overflow", overflow, 1'b0);
        check("t6_frame_error", frame_error, 1'b0);
        check("t6_out_valid", out_valid, 1'b0);
        wait_neg(4);
        check("t6_level_later", level, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
